// File: rtl/vga_timing.sv
// vga_timing: 800x600@60 raster counters, sync and blanking, all registered.
// Ports: pclk/rst in; hcount/vcount, hsync/hblnk, vsync/vblnk out. Optional macro
// VGA_FRAME_CNT_EN adds frame_start (one-cycle pulse at frame wrap) and frame_cnt.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int CNT_W    = 11
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic             hsync,
  output logic             hblnk,
  output logic [CNT_W-1:0] vcount,
  output logic             vsync,
  output logic             vblnk
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLK  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_BLK  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vsync_q, vsync_d;
  logic             vblnk_q, vblnk_d;
  logic             h_last, v_last, wrap;

  assign h_last = (hcount_q == H_LAST);
  assign v_last = (vcount_q == V_LAST);
  assign wrap   = h_last && v_last;

  // Flags decode the next counts so they land in the same register
  // stage as the counts themselves.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_last) begin
      hcount_d = '0;
      vcount_d = v_last ? '0 : vcount_q + 1'b1;
    end
    hblnk_d = (hcount_d >= H_BLK);
    hsync_d = (hcount_d >= H_SS) && (hcount_d < H_SE);
    vblnk_d = (vcount_d >= V_BLK);
    vsync_d = (vcount_d >= V_SS) && (vcount_d < V_SE);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign hblnk  = hblnk_q;
  assign vsync  = vsync_q;
  assign vblnk  = vblnk_q;

`ifdef VGA_FRAME_CNT_EN
  logic        fstart_q, fstart_d;
  logic [15:0] fcnt_q, fcnt_d;

  // Pulse only on a real wrap; reset lands on (0,0) without one.
  always_comb begin
    fstart_d = wrap;
    fcnt_d   = wrap ? fcnt_q + 16'd1 : fcnt_q;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fstart_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign frame_start = fstart_q;
  assign frame_cnt   = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing at full 800x600 size
// (one line) and at a reduced geometry (full frames).
`timescale 1ns/1ps
module tb_vga_timing;

  localparam int W = 11;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic         rst_a, rst_b;
  logic [W-1:0] hc_a, vc_a, hc_b, vc_b;
  logic         hs_a, hb_a, vs_a, vb_a;
  logic         hs_b, hb_b, vs_b, vb_b;
`ifdef VGA_FRAME_CNT_EN
  logic         fs_a, fs_b;
  logic [15:0]  fc_a, fc_b;
`endif

  int errors = 0;
  int checks = 0;

  vga_timing u_a (
    .pclk(pclk), .rst(rst_a),
    .hcount(hc_a), .hsync(hs_a), .hblnk(hb_a),
    .vcount(vc_a), .vsync(vs_a), .vblnk(vb_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(fs_a), .frame_cnt(fc_a)
`endif
  );

  // Small geometry: H 8/2/3/2 = 15, V 6/1/2/2 = 11, frame = 165 clocks.
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CNT_W(W)
  ) u_b (
    .pclk(pclk), .rst(rst_b),
    .hcount(hc_b), .hsync(hs_b), .hblnk(hb_b),
    .vcount(vc_b), .vsync(vs_b), .vblnk(vb_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(fs_b), .frame_cnt(fc_b)
`endif
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_a(int h, int v);
    check("a_hcount", 32'(hc_a), 32'(h));
    check("a_vcount", 32'(vc_a), 32'(v));
    check("a_hblnk", 32'(hb_a), 32'(h >= 800));
    check("a_hsync", 32'(hs_a), 32'(h >= 840 && h < 968));
    check("a_vblnk", 32'(vb_a), 32'(v >= 600));
    check("a_vsync", 32'(vs_a), 32'(v >= 601 && v < 605));
  endtask

  task automatic chk_b(int h, int v);
    check("b_hcount", 32'(hc_b), 32'(h));
    check("b_vcount", 32'(vc_b), 32'(v));
    check("b_hblnk", 32'(hb_b), 32'(h >= 8));
    check("b_hsync", 32'(hs_b), 32'(h >= 10 && h < 13));
    check("b_vblnk", 32'(vb_b), 32'(v >= 6));
    check("b_vsync", 32'(vs_b), 32'(v >= 7 && v < 9));
  endtask

  task automatic chk_zero_a();
    check("a_rst_h", 32'(hc_a), 0);
    check("a_rst_v", 32'(vc_a), 0);
    check("a_rst_flags", 32'({hs_a, hb_a, vs_a, vb_a}), 0);
  endtask

  task automatic chk_zero_b();
    check("b_rst_h", 32'(hc_b), 0);
    check("b_rst_v", 32'(vc_b), 0);
    check("b_rst_flags", 32'({hs_b, hb_b, vs_b, vb_b}), 0);
  endtask

  initial begin
    int hs_cnt, vs_cnt, vb_cnt, e, pulses;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #3;
    chk_zero_a();
    chk_zero_b();
    repeat (3) step();
    chk_zero_a();
    chk_zero_b();
`ifdef VGA_FRAME_CNT_EN
    check("a_fs_rst", 32'(fs_a), 0);
    check("a_fc_rst", 32'(fc_a), 0);
`endif

    // Release: first edge gives (1,0).
    @(negedge pclk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    chk_a(1, 0);
    chk_b(1, 0);
`ifdef VGA_FRAME_CNT_EN
    check("a_fs_release", 32'(fs_a), 0);
`endif

    // Full line at 800x600, through the 1055->0 wrap.
    hs_cnt = 0;
    for (int i = 2; i <= 1057; i++) begin
      step();
      chk_a(i % 1056, (i >= 1056) ? 1 : 0);
      if (hs_a) hs_cnt++;
    end
    check("a_hsync_len", 32'(hs_cnt), 128);

    // Async reset mid-hsync at (900,1), between edges.
    repeat (899) step();
    chk_a(900, 1);
    #3 rst_a = 1'b1;
    #1 chk_zero_a();
    step();
    chk_zero_a();
    @(negedge pclk);
    rst_a = 1'b0;
    step();
    chk_a(1, 0);
    step();
    chk_a(2, 0);

    // Full small frame from a fresh reset.
    @(negedge pclk);
    rst_b = 1'b1;
    step();
    chk_zero_b();
    @(negedge pclk);
    rst_b = 1'b0;
    step();
    chk_b(1, 0);
    vs_cnt = 0;
    vb_cnt = 0;
    for (int i = 2; i <= 166; i++) begin
      step();
      e = i % 165;
      chk_b(e % 15, e / 15);
      if (vs_b) vs_cnt++;
      if (vb_b) vb_cnt++;
      if (i == 165) begin
        check("b_wrap_h", 32'(hc_b), 0);
        check("b_wrap_v", 32'(vc_b), 0);
      end
    end
    check("b_vsync_len", 32'(vs_cnt), 30);
    check("b_vblnk_len", 32'(vb_cnt), 75);

    // Async reset inside both sync pulses at (11,7).
    repeat (115) step();
    chk_b(11, 7);
    #3 rst_b = 1'b1;
    #1 chk_zero_b();
    @(negedge pclk);
    rst_b = 1'b0;
    step();
    chk_b(1, 0);

`ifdef VGA_FRAME_CNT_EN
    check("b_fs_release", 32'(fs_b), 0);
    check("b_fc_release", 32'(fc_b), 0);
    pulses = 0;
    for (int i = 0; i < 495; i++) begin
      step();
      if (fs_b) begin
        pulses++;
        check("b_fs_h", 32'(hc_b), 0);
        check("b_fs_v", 32'(vc_b), 0);
        check("b_fc_val", 32'(fc_b), 32'(pulses));
      end
    end
    check("b_fs_count", 32'(pulses), 3);
    check("b_fc_final", 32'(fc_b), 3);
`else
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      e = i + 2;
      chk_b(e % 15, e / 15);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
